pred_ras: RTL

PRED_RAS -- requirements
Module: pred_ras

---
 rtl/pred_ras_if.sv | 44 ++++
 rtl/pred_ras.sv | 94 +++++++++
 2 files changed

// File: rtl/pred_ras_if.sv
// Fetch/execute-side signal bundle for the return-address stack predictor.
// The master drives fetch and restore requests; the slave (pred_ras) drives stack state and statistics.
interface pred_ras_if #(
   parameter int RAS_DEPTH = 16,
   parameter int RAS_W     = 4,
   parameter int CNT_W     = 16
);
   logic                      f_allow_in;
   logic                      f_push;
   logic                      f_pop;
   logic [31:0]               f_push_addr;
   logic [31:0]               f_top;
   logic                      f_top_valid;
   logic [RAS_W-1:0]          f_sp;
   logic [RAS_W:0]            f_count;
   logic [RAS_DEPTH*32-1:0]   f_snapshot;

   logic                      e_restore;
   logic [RAS_W-1:0]          e_restore_sp;
   logic [RAS_W:0]            e_restore_count;
   logic [RAS_DEPTH*32-1:0]   e_restore_snapshot;
   logic                      e_push;
   logic                      e_pop;
   logic [31:0]               e_push_addr;

   logic [CNT_W-1:0]          ovf_cnt;
   logic [CNT_W-1:0]          unf_cnt;

   modport master (
      output f_allow_in, f_push, f_pop, f_push_addr,
      output e_restore, e_restore_sp, e_restore_count, e_restore_snapshot,
      output e_push, e_pop, e_push_addr,
      input  f_top, f_top_valid, f_sp, f_count, f_snapshot,
      input  ovf_cnt, unf_cnt
   );

   modport slave (
      input  f_allow_in, f_push, f_pop, f_push_addr,
      input  e_restore, e_restore_sp, e_restore_count, e_restore_snapshot,
      input  e_push, e_pop, e_push_addr,
      output f_top, f_top_valid, f_sp, f_count, f_snapshot,
      output ovf_cnt, unf_cnt
   );
endinterface

// File: rtl/pred_ras.sv
// Speculative return-address stack: circular buffer where sp points at the newest entry,
// with single-cycle checkpoint restore from execute and saturating overflow/underflow counters.
module pred_ras #(
   parameter int RAS_DEPTH = 16,
   parameter int RAS_W     = 4,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       rst,
   pred_ras_if.slave  bus
);

   localparam logic [RAS_W:0] FULL = (RAS_W+1)'(RAS_DEPTH);

   logic [RAS_W-1:0] sp_q, sp_d;
   logic [RAS_W:0]   count_q, count_d;
   logic [31:0]      mem_q [RAS_DEPTH];
   logic [31:0]      mem_d [RAS_DEPTH];
   logic [CNT_W-1:0] ovf_q, unf_q;
   logic             ovf_ev, unf_ev;

   logic [RAS_W-1:0] base_sp;
   logic [RAS_W:0]   base_count;
   logic             do_push, do_pop;
   logic [31:0]      wr_data;

   // A restore replaces the base state; the redirecting instruction's own push/pop is then replayed on it.
   always_comb begin
      base_sp    = bus.e_restore ? bus.e_restore_sp    : sp_q;
      base_count = bus.e_restore ? bus.e_restore_count : count_q;
      do_push    = bus.e_restore ? bus.e_push : (bus.f_allow_in & bus.f_push);
      do_pop     = bus.e_restore ? bus.e_pop  : (bus.f_allow_in & bus.f_pop);
      wr_data    = bus.e_restore ? bus.e_push_addr : bus.f_push_addr;

      // NOTE: every combinational output gets a default first so no path can infer a latch.
      mem_d   = mem_q;
      sp_d    = base_sp;
      count_d = base_count;
      ovf_ev  = 1'b0;
      unf_ev  = 1'b0;

      if (bus.e_restore) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_d[i] = bus.e_restore_snapshot[32*i +: 32];
         end
      end

      if (do_push && do_pop) begin
         mem_d[base_sp] = wr_data;
         if (base_count == '0) count_d = (RAS_W+1)'(1);
      end else if (do_push) begin
         sp_d        = base_sp + RAS_W'(1);
         mem_d[sp_d] = wr_data;
         if (base_count == FULL) ovf_ev = 1'b1;
         else                    count_d = base_count + (RAS_W+1)'(1);
      end else if (do_pop) begin
         if (base_count != '0) begin
            sp_d    = base_sp - RAS_W'(1);
            count_d = base_count - (RAS_W+1)'(1);
         end else begin
            unf_ev = 1'b1;
         end
      end
   end

   // NOTE: the entry array is reset too, so a freshly reset stack exposes a defined all-zero snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_q    <= '1;
         count_q <= '0;
         ovf_q   <= '0;
         unf_q   <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         mem_q   <= mem_d;
         if (ovf_ev && ovf_q != '1) ovf_q <= ovf_q + CNT_W'(1);
         if (unf_ev && unf_q != '1) unf_q <= unf_q + CNT_W'(1);
      end
   end

   assign bus.f_top       = (count_q != '0) ? mem_q[sp_q] : 32'h0;
   assign bus.f_top_valid = (count_q != '0);
   assign bus.f_sp        = sp_q;
   assign bus.f_count     = count_q;
   assign bus.ovf_cnt     = ovf_q;
   assign bus.unf_cnt     = unf_q;

   for (genvar g = 0; g < RAS_DEPTH; g++) begin : g_snap
      assign bus.f_snapshot[32*g +: 32] = mem_q[g];
   end

endmodule
